jvm_byte_fetch: RTL and testbench

Instruction-RAM reader that supplies JVM bytecode bytes to the translation state machine. It issues sequential reads to the synchronous instruction RAM and holds the returned bytes in a 2-entry buffer. Each byte is presented on `iram_data` with a valid flag and its bytecode PC, and is held stable while the consumer asserts `waiting`. It sits between the instruction RAM and `state_machine`, replacing the free-running byte source with a flow-controlled one, and supports redirect (branch) and end-of-method detection.

---
 rtl/jvm_byte_fetch.sv | 119 +++++++++++
 tb/tb_jvm_byte_fetch.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jvm_byte_fetch.sv
// Flow-controlled bytecode fetcher: sequential reads from a synchronous instruction RAM
// into a 2-entry buffer, with stall, redirect, restart and end-of-method detection.
module jvm_byte_fetch #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_pc,
   input  logic [ADDR_W-1:0] end_pc,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              waiting,
   output logic              iram_en,
   output logic [ADDR_W-1:0] iram_adr,
   input  logic [7:0]        iram_rdata,
   output logic [7:0]        iram_data,
   output logic              data_valid,
   output logic [ADDR_W-1:0] byte_pc,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_fetch_pc;
   logic [ADDR_W-1:0] r_end_pc;
   logic [ADDR_W-1:0] r_inflight_pc;
   logic              r_inflight;
   logic [1:0]        r_count;
   logic [7:0]        r_data0, r_data1;
   logic [ADDR_W-1:0] r_pc0, r_pc1;

   logic              w_run;
   logic              w_pop;
   logic              w_push;
   logic              w_redirect;
   logic              w_issue;
   logic              w_wr_hi;
   logic [2:0]        w_occ;
   logic [2:0]        w_limit;

   assign w_run      = (r_state == S_RUN);
   assign w_pop      = (r_count != 2'd0) && !waiting;
   assign w_push     = r_inflight;
   assign w_redirect = redirect && w_run && !start;

   // occupancy after this cycle's pop must leave room for the read being issued
   assign w_occ      = {1'b0, r_count} + {2'b00, r_inflight};
   assign w_limit    = 3'd2 + {2'b00, w_pop};
   assign w_issue    = w_run && (r_fetch_pc != r_end_pc) && (w_occ < w_limit);

   // returning byte lands in entry 1 only if entry 0 stays occupied after the pop
   assign w_wr_hi    = (r_count == 2'd2) || ((r_count == 2'd1) && !w_pop);

   assign iram_en    = w_issue;
   assign iram_adr   = r_fetch_pc;
   assign iram_data  = r_data0;
   assign byte_pc    = r_pc0;
   assign data_valid = (r_count != 2'd0);
   assign busy       = w_run;
   assign done       = (r_state == S_DONE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_fetch_pc    <= '0;
         r_end_pc      <= '0;
         r_inflight_pc <= '0;
         r_inflight    <= 1'b0;
         r_count       <= 2'd0;
         r_data0       <= '0;
         r_data1       <= '0;
         r_pc0         <= '0;
         r_pc1         <= '0;
      end else if (start) begin
         r_state    <= S_RUN;
         r_fetch_pc <= start_pc;
         r_end_pc   <= end_pc;
         r_inflight <= 1'b0;
         r_count    <= 2'd0;
      end else if (w_redirect) begin
         r_fetch_pc <= redirect_pc;
         r_inflight <= 1'b0;
         r_count    <= 2'd0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_fetch_pc    <= r_fetch_pc + ADDR_W'(1);
            r_inflight_pc <= r_fetch_pc;
         end
         if (w_pop) begin
            r_data0 <= r_data1;
            r_pc0   <= r_pc1;
         end
         if (w_push) begin
            if (w_wr_hi) begin
               r_data1 <= iram_rdata;
               r_pc1   <= r_inflight_pc;
            end else begin
               r_data0 <= iram_rdata;
               r_pc0   <= r_inflight_pc;
            end
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
         if (w_run && (r_fetch_pc == r_end_pc) && !r_inflight && (r_count == 2'd0))
            r_state <= S_DONE;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
      !(w_push && !w_pop && (r_count == 2'd2) && !start && !w_redirect));

endmodule

// File: tb/tb_jvm_byte_fetch.sv
// Directed bench for jvm_byte_fetch: streaming, stall, redirect, boundaries, reset, collision.
module tb_jvm_byte_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, redirect, waiting;
   logic [11:0] start_pc, end_pc, redirect_pc;
   logic        iram_en;
   logic [11:0] iram_adr;
   logic [7:0]  iram_rdata;
   logic [7:0]  iram_data;
   logic        data_valid;
   logic [11:0] byte_pc;
   logic        busy, done;

   logic        s4_start, s4_redirect, s4_waiting;
   logic [3:0]  s4_start_pc, s4_end_pc, s4_redirect_pc;
   logic        s4_iram_en;
   logic [3:0]  s4_iram_adr;
   logic [7:0]  s4_iram_rdata;
   logic [7:0]  s4_iram_data;
   logic        s4_data_valid;
   logic [3:0]  s4_byte_pc;
   logic        s4_busy, s4_done;

   logic [7:0]  mem  [0:4095];
   logic [7:0]  mem4 [0:15];

   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   jvm_byte_fetch #(.ADDR_W(12)) dut (
      .clk(clk), .reset(reset), .start(start), .start_pc(start_pc), .end_pc(end_pc),
      .redirect(redirect), .redirect_pc(redirect_pc), .waiting(waiting),
      .iram_en(iram_en), .iram_adr(iram_adr), .iram_rdata(iram_rdata),
      .iram_data(iram_data), .data_valid(data_valid), .byte_pc(byte_pc),
      .busy(busy), .done(done)
   );

   jvm_byte_fetch #(.ADDR_W(4)) dut4 (
      .clk(clk), .reset(reset), .start(s4_start), .start_pc(s4_start_pc), .end_pc(s4_end_pc),
      .redirect(s4_redirect), .redirect_pc(s4_redirect_pc), .waiting(s4_waiting),
      .iram_en(s4_iram_en), .iram_adr(s4_iram_adr), .iram_rdata(s4_iram_rdata),
      .iram_data(s4_iram_data), .data_valid(s4_data_valid), .byte_pc(s4_byte_pc),
      .busy(s4_busy), .done(s4_done)
   );

   always @(posedge clk) begin
      if (iram_en)    iram_rdata    <= mem[iram_adr];
      if (s4_iram_en) s4_iram_rdata <= mem4[s4_iram_adr];
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [11:0] spc, input logic [11:0] epc);
      start_pc = spc;
      end_pc   = epc;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      #1;
      n_checks++; if (iram_en !== 1'b0)     begin n_fail++; $display("FAIL rst_iram_en got %0h exp 0", iram_en); end
      n_checks++; if (iram_adr !== 12'd0)   begin n_fail++; $display("FAIL rst_iram_adr got %0h exp 0", iram_adr); end
      n_checks++; if (iram_data !== 8'd0)   begin n_fail++; $display("FAIL rst_iram_data got %0h exp 0", iram_data); end
      n_checks++; if (data_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_data_valid got %0h exp 0", data_valid); end
      n_checks++; if (byte_pc !== 12'd0)    begin n_fail++; $display("FAIL rst_byte_pc got %0h exp 0", byte_pc); end
      n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL rst_busy got %0h exp 0", busy); end
      n_checks++; if (done !== 1'b0)        begin n_fail++; $display("FAIL rst_done got %0h exp 0", done); end
      tick();
      reset = 1'b1;
      tick();
      n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL idle_busy got %0h exp 0", busy); end
   endtask

   task automatic test_straight;
      int c;
      do_start(12'd0, 12'd6);
      n_checks++; if (iram_en !== 1'b1 || iram_adr !== 12'd0) begin n_fail++; $display("FAIL first_issue got en=%0h adr=%0h exp en=1 adr=0", iram_en, iram_adr); end
      n_checks++; if (busy !== 1'b1)        begin n_fail++; $display("FAIL run_busy got %0h exp 1", busy); end
      tick();
      n_checks++; if (data_valid !== 1'b0)  begin n_fail++; $display("FAIL latency_dv got %0h exp 0", data_valid); end
      tick();
      for (int k = 0; k < 6; k++) begin
         n_checks++;
         if (data_valid !== 1'b1 || iram_data !== 8'(11 + k) || byte_pc !== 12'(k)) begin
            n_fail++;
            $display("FAIL stream_%0d got dv=%0h data=%0d pc=%0d exp dv=1 data=%0d pc=%0d", k, data_valid, iram_data, byte_pc, 11 + k, k);
         end
         tick();
      end
      n_checks++; if (done !== 1'b0 || data_valid !== 1'b0) begin n_fail++; $display("FAIL pre_done got done=%0h dv=%0h exp 0 0", done, data_valid); end
      tick();
      n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL done_rise got done=%0h busy=%0h exp 1 0", done, busy); end
      c = 0;
   endtask

   task automatic test_stall;
      do_start(12'd0, 12'd6);
      tick(); tick(); tick(); tick();
      n_checks++; if (iram_data !== 8'd13 || byte_pc !== 12'd2) begin n_fail++; $display("FAIL stall_pre got data=%0d pc=%0d exp 13 2", iram_data, byte_pc); end
      waiting = 1'b1;
      tick();
      for (int j = 1; j <= 4; j++) begin
         n_checks++;
         if (data_valid !== 1'b1 || iram_data !== 8'd13 || byte_pc !== 12'd2 || iram_en !== 1'b1 - 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold_%0d got dv=%0h data=%0d pc=%0d en=%0h exp 1 13 2 0", j, data_valid, iram_data, byte_pc, iram_en);
         end
         if (j == 2) begin
            n_checks++; if (dut.r_count !== 2'd2) begin n_fail++; $display("FAIL stall_count got %0d exp 2", dut.r_count); end
         end
         if (j == 4) waiting = 1'b0;
         tick();
      end
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (data_valid !== 1'b1 || iram_data !== 8'(14 + k) || byte_pc !== 12'(3 + k)) begin
            n_fail++;
            $display("FAIL after_stall_%0d got dv=%0h data=%0d pc=%0d exp 1 %0d %0d", k, data_valid, iram_data, byte_pc, 14 + k, 3 + k);
         end
         tick();
      end
      for (int c = 0; c < 10 && done !== 1'b1; c++) tick();
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL stall_done_timeout got %0h exp 1", done); end
   endtask

   task automatic test_redirect;
      do_start(12'd0, 12'd64);
      tick(); tick(); tick(); tick(); tick();
      n_checks++; if (byte_pc !== 12'd3 || iram_data !== 8'd14) begin n_fail++; $display("FAIL redir_pre got pc=%0d data=%0d exp 3 14", byte_pc, iram_data); end
      redirect_pc = 12'd40;
      redirect    = 1'b1;
      tick();
      redirect    = 1'b0;
      n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL redir_dv0 got %0h exp 0", data_valid); end
      n_checks++; if (iram_en !== 1'b1 || iram_adr !== 12'd40) begin n_fail++; $display("FAIL redir_issue got en=%0h adr=%0d exp 1 40", iram_en, iram_adr); end
      tick();
      n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL redir_dv1 got %0h exp 0", data_valid); end
      tick();
      n_checks++; if (data_valid !== 1'b1 || iram_data !== 8'hA7 || byte_pc !== 12'd40) begin n_fail++; $display("FAIL redir_target got dv=%0h data=%0h pc=%0d exp 1 a7 40", data_valid, iram_data, byte_pc); end
      tick();
      n_checks++; if (iram_data !== 8'd52 || byte_pc !== 12'd41) begin n_fail++; $display("FAIL redir_next got data=%0d pc=%0d exp 52 41", iram_data, byte_pc); end
   endtask

   task automatic test_boundary;
      do_start(12'd9, 12'd9);
      n_checks++; if (iram_en !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL empty_run got en=%0h busy=%0h done=%0h exp 0 1 0", iram_en, busy, done); end
      tick();
      n_checks++; if (done !== 1'b1 || iram_en !== 1'b0) begin n_fail++; $display("FAIL empty_done got done=%0h en=%0h exp 1 0", done, iram_en); end
      redirect_pc = 12'd3;
      redirect    = 1'b1;
      tick();
      redirect    = 1'b0;
      n_checks++; if (done !== 1'b1 || busy !== 1'b0 || iram_en !== 1'b0) begin n_fail++; $display("FAIL redir_in_done got done=%0h busy=%0h en=%0h exp 1 0 0", done, busy, iram_en); end
      do_start(12'd0, 12'd20);
      tick(); tick();
      redirect_pc = 12'd20;
      redirect    = 1'b1;
      tick();
      redirect    = 1'b0;
      n_checks++; if (busy !== 1'b1 || data_valid !== 1'b0 || iram_en !== 1'b0) begin n_fail++; $display("FAIL redir_end_run got busy=%0h dv=%0h en=%0h exp 1 0 0", busy, data_valid, iram_en); end
      tick();
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL redir_end_done got %0h exp 1", done); end
   endtask

   task automatic test_wrap;
      logic [3:0] exp_pc [4];
      exp_pc = '{4'd14, 4'd15, 4'd0, 4'd1};
      s4_start_pc = 4'd14;
      s4_end_pc   = 4'd2;
      s4_start    = 1'b1;
      tick();
      s4_start    = 1'b0;
      tick(); tick();
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (s4_data_valid !== 1'b1 || s4_byte_pc !== exp_pc[k] || s4_iram_data !== 8'(exp_pc[k] * 3 + 1)) begin
            n_fail++;
            $display("FAIL wrap_%0d got dv=%0h pc=%0d data=%0d exp 1 %0d %0d", k, s4_data_valid, s4_byte_pc, s4_iram_data, exp_pc[k], exp_pc[k] * 3 + 1);
         end
         tick();
      end
      n_checks++; if (s4_data_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_end_dv got %0h exp 0", s4_data_valid); end
      tick();
      n_checks++; if (s4_done !== 1'b1) begin n_fail++; $display("FAIL wrap_done got %0h exp 1", s4_done); end
   endtask

   task automatic test_reset_mid;
      do_start(12'd0, 12'd64);
      for (int k = 0; k < 6; k++) begin
         waiting = k[0];
         tick();
      end
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if (iram_en !== 1'b0 || iram_adr !== 12'd0 || iram_data !== 8'd0 || data_valid !== 1'b0 ||
          byte_pc !== 12'd0 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset got en=%0h adr=%0h data=%0h dv=%0h pc=%0h busy=%0h done=%0h exp all 0",
                  iram_en, iram_adr, iram_data, data_valid, byte_pc, busy, done);
      end
      tick();
      reset   = 1'b1;
      waiting = 1'b0;
      tick(); tick();
      n_checks++; if (data_valid !== 1'b0 || busy !== 1'b0 || iram_en !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle got dv=%0h busy=%0h en=%0h exp 0 0 0", data_valid, busy, iram_en); end
      do_start(12'd30, 12'd33);
      tick(); tick();
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (data_valid !== 1'b1 || iram_data !== 8'(41 + k) || byte_pc !== 12'(30 + k)) begin
            n_fail++;
            $display("FAIL restart_%0d got dv=%0h data=%0d pc=%0d exp 1 %0d %0d", k, data_valid, iram_data, byte_pc, 41 + k, 30 + k);
         end
         tick();
      end
   endtask

   task automatic test_collision;
      start_pc    = 12'd20;
      end_pc      = 12'd25;
      redirect_pc = 12'd50;
      start       = 1'b1;
      redirect    = 1'b1;
      tick();
      start       = 1'b0;
      redirect    = 1'b0;
      n_checks++; if (iram_adr !== 12'd20 || iram_en !== 1'b1) begin n_fail++; $display("FAIL coll_issue got en=%0h adr=%0d exp 1 20", iram_en, iram_adr); end
      tick(); tick();
      n_checks++; if (data_valid !== 1'b1 || byte_pc !== 12'd20 || iram_data !== 8'd31) begin n_fail++; $display("FAIL coll_first got dv=%0h pc=%0d data=%0d exp 1 20 31", data_valid, byte_pc, iram_data); end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'(i + 11);
      mem[40] = 8'hA7;
      for (int i = 0; i < 16; i++) mem4[i] = 8'(i * 3 + 1);
      start = 1'b0; redirect = 1'b0; waiting = 1'b0;
      start_pc = '0; end_pc = '0; redirect_pc = '0;
      s4_start = 1'b0; s4_redirect = 1'b0; s4_waiting = 1'b0;
      s4_start_pc = '0; s4_end_pc = '0; s4_redirect_pc = '0;
      test_reset();
      test_straight();
      test_stall();
      test_redirect();
      test_boundary();
      test_wrap();
      test_reset_mid();
      test_collision();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule
